// File: rtl/sync_fifo_flex.sv
// ---------------------------------------------------------------------------
// sync_fifo_flex -- single-clock FIFO with arbitrary depth, occupancy count,
// runtime almost-full/almost-empty thresholds, sticky overflow/underflow
// flags and a selectable read mode (show-ahead or registered read).
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), async active-low reset
//   i_flush            synchronous clear of all state
//   i_push, i_wdata    write request and data
//   i_pop              read request
//   i_afull_th         almost-full threshold  (o_afull  = count >= th)
//   i_aempty_th        almost-empty threshold (o_aempty = count <= th)
//   o_rdata, o_rvalid  read data and its valid
//   o_count            occupancy 0..DEPTH
//   o_full, o_empty    occupancy flags
//   o_afull, o_aempty  threshold flags (combinational on count)
//   o_overflow         sticky: a push was rejected
//   o_underflow        sticky: a pop was rejected
// ---------------------------------------------------------------------------
module sync_fifo_flex #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter bit FWFT  = 1'b1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic [CW-1:0]    i_afull_th,
    input  logic [CW-1:0]    i_aempty_th,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rvalid,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_afull,
    output logic             o_aempty,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             ovf_q, udf_q;
    logic             pop_ok, push_ok;

    // Flags derive from count only; pointers never need an extra wrap bit.
    assign o_count  = count;
    assign o_full   = (count == FULL_CNT);
    assign o_empty  = (count == '0);
    assign o_afull  = (count >= i_afull_th);
    assign o_aempty = (count <= i_aempty_th);
    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~o_full | pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
            if (pop_ok)
                rptr <= (rptr == LAST_IDX) ? '0 : rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_push && !push_ok) ovf_q <= 1'b1;
            if (i_pop  && !pop_ok)  udf_q <= 1'b1;
        end
    end

    // Storage is not reset; writes are suppressed during flush.
    always_ff @(posedge i_clk) begin
        if (push_ok && !i_flush)
            mem[wptr] <= i_wdata;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word shown combinationally; zero when nothing is held.
            assign o_rvalid = ~o_empty;
            assign o_rdata  = o_empty ? '0 : mem[rptr];
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;
            // mem[rptr] is sampled before this edge's write lands, so a
            // same-index push/pop returns the old word.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (i_flush) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= pop_ok;
                    if (pop_ok)
                        rdata_q <= mem[rptr];
                end
            end
            assign o_rvalid = rvalid_q;
            assign o_rdata  = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flex -- drives two DEPTH=5 instances (show-ahead and
// registered read) with shared stimulus and compares every output against a
// queue-based reference model each cycle.
// ---------------------------------------------------------------------------
module tb_sync_fifo_flex;

    localparam int WIDTH = 16;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_push = 1'b0;
    logic             i_pop = 1'b0;
    logic [WIDTH-1:0] i_wdata = '0;
    logic [CW-1:0]    i_afull_th = CW'(4);
    logic [CW-1:0]    i_aempty_th = CW'(1);

    logic [WIDTH-1:0] rdata_a, rdata_b;
    logic             rvalid_a, rvalid_b;
    logic [CW-1:0]    count_a, count_b;
    logic             full_a, full_b, empty_a, empty_b;
    logic             afull_a, afull_b, aempty_a, aempty_b;
    logic             ovf_a, ovf_b, udf_a, udf_b;

    sync_fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_push(i_push), .i_wdata(i_wdata), .i_pop(i_pop),
        .i_afull_th(i_afull_th), .i_aempty_th(i_aempty_th),
        .o_rdata(rdata_a), .o_rvalid(rvalid_a), .o_count(count_a),
        .o_full(full_a), .o_empty(empty_a), .o_afull(afull_a),
        .o_aempty(aempty_a), .o_overflow(ovf_a), .o_underflow(udf_a)
    );

    sync_fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) u_reg (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_push(i_push), .i_wdata(i_wdata), .i_pop(i_pop),
        .i_afull_th(i_afull_th), .i_aempty_th(i_aempty_th),
        .o_rdata(rdata_b), .o_rvalid(rvalid_b), .o_count(count_b),
        .o_full(full_b), .o_empty(empty_b), .o_afull(afull_b),
        .o_aempty(aempty_b), .o_overflow(ovf_b), .o_underflow(udf_b)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a queue holding the stored words in order.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf, m_udf;
    logic [WIDTH-1:0] m_rd0;
    bit               m_rv0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rd0 = '0;
        m_rv0 = 1'b0;
    endtask

    task automatic model_edge(input bit push, input logic [WIDTH-1:0] d,
                              input bit pop, input bit flush);
        bit pop_ok, push_ok;
        if (flush) begin
            model_reset();
            return;
        end
        pop_ok  = pop && (q.size() > 0);
        push_ok = push && ((q.size() < DEPTH) || pop_ok);
        m_rv0 = pop_ok;
        if (pop_ok) begin
            m_rd0 = q[0];
            void'(q.pop_front());
        end
        if (push_ok) q.push_back(d);
        if (push && !push_ok) m_ovf = 1'b1;
        if (pop && !pop_ok)   m_udf = 1'b1;
    endtask

    task automatic check_all(input string ph);
        int n;
        logic [WIDTH-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        chk({ph, ":count_a"}, 32'(count_a), 32'(n));
        chk({ph, ":count_b"}, 32'(count_b), 32'(n));
        chk({ph, ":full_a"},  32'(full_a),  32'(n == DEPTH));
        chk({ph, ":full_b"},  32'(full_b),  32'(n == DEPTH));
        chk({ph, ":empty_a"}, 32'(empty_a), 32'(n == 0));
        chk({ph, ":empty_b"}, 32'(empty_b), 32'(n == 0));
        chk({ph, ":afull_a"}, 32'(afull_a), 32'(n >= int'(i_afull_th)));
        chk({ph, ":afull_b"}, 32'(afull_b), 32'(n >= int'(i_afull_th)));
        chk({ph, ":aempty_a"}, 32'(aempty_a), 32'(n <= int'(i_aempty_th)));
        chk({ph, ":aempty_b"}, 32'(aempty_b), 32'(n <= int'(i_aempty_th)));
        chk({ph, ":ovf_a"}, 32'(ovf_a), 32'(m_ovf));
        chk({ph, ":ovf_b"}, 32'(ovf_b), 32'(m_ovf));
        chk({ph, ":udf_a"}, 32'(udf_a), 32'(m_udf));
        chk({ph, ":udf_b"}, 32'(udf_b), 32'(m_udf));
        chk({ph, ":rvalid_a"}, 32'(rvalid_a), 32'(n > 0));
        chk({ph, ":rdata_a"},  32'(rdata_a),  32'(head));
        chk({ph, ":rvalid_b"}, 32'(rvalid_b), 32'(m_rv0));
        chk({ph, ":rdata_b"},  32'(rdata_b),  32'(m_rd0));
    endtask

    // One cycle: apply inputs, check outputs, advance model at the edge.
    task automatic step(input bit push, input logic [WIDTH-1:0] d,
                        input bit pop, input bit flush, input string ph);
        i_push  = push;
        i_wdata = d;
        i_pop   = pop;
        i_flush = flush;
        #1;
        check_all(ph);
        @(posedge i_clk);
        model_edge(push, d, pop, flush);
        @(negedge i_clk);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Fill 0x11..0x15, afull at 4, full at 5, head stays 0x11.
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(16'h11 + i), 1'b0, 1'b0, "fill");
        step(1'b1, 16'h00AA, 1'b0, 1'b0, "ovf_push");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, "drain");
        step(1'b0, '0, 1'b0, 1'b0, "idle1");

        // Interleaved traffic forcing two pointer wraps.
        for (int i = 0; i < 12; i++)
            step(1'b1, WIDTH'(16'h100 + i), (i % 3) != 0, 1'b0, "wrap");
        while (q.size() > 0) step(1'b0, '0, 1'b1, 1'b0, "wrap_drain");

        // Empty with push+pop together: pop rejected, push kept.
        step(1'b1, 16'h0007, 1'b1, 1'b0, "emp_pp");
        step(1'b0, '0, 1'b0, 1'b0, "emp_pp_chk");

        // Registered-read latency: push 3, 4, pop, pop.
        step(1'b0, '0, 1'b0, 1'b1, "flush0");
        step(1'b1, 16'h0003, 1'b0, 1'b0, "r_push3");
        step(1'b1, 16'h0004, 1'b0, 1'b0, "r_push4");
        step(1'b0, '0, 1'b1, 1'b0, "r_pop1");
        step(1'b0, '0, 1'b1, 1'b0, "r_pop2");
        step(1'b0, '0, 1'b0, 1'b0, "r_idle1");
        step(1'b0, '0, 1'b0, 1'b0, "r_idle2");

        // Full, push+pop together: same-index write/read, no overflow.
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(16'h200 + i), 1'b0, 1'b0, "fill2");
        step(1'b1, 16'h0300, 1'b1, 1'b0, "full_pp");
        step(1'b1, 16'h0301, 1'b0, 1'b0, "ovf2");
        step(1'b0, '0, 1'b0, 1'b0, "ovf2_chk");

        // Flush with a concurrent push: flags clear, pushed word absent.
        step(1'b1, 16'h00BB, 1'b0, 1'b1, "flush_push");
        step(1'b0, '0, 1'b0, 1'b0, "post_flush");
        step(1'b0, '0, 1'b1, 1'b0, "post_flush_pop");

        // Randomized traffic with changing thresholds.
        for (int i = 0; i < 400; i++) begin
            if ((i % 37) == 0) begin
                i_afull_th  = CW'($urandom_range(0, DEPTH + 1));
                i_aempty_th = CW'($urandom_range(0, DEPTH + 1));
            end
            step(($urandom_range(0, 99) < 55), WIDTH'($urandom),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 2), "rand");
        end

        // Asynchronous reset in the middle of a burst.
        i_afull_th  = CW'(4);
        i_aempty_th = CW'(1);
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0, "burst");
        step(1'b1, 16'h0ABC, 1'b1, 1'b0, "burst_pp");
        i_push = 1'b1;
        i_pop  = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        i_push = 1'b0;
        i_pop  = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, 16'h0055, 1'b0, 1'b0, "after_rst");
        step(1'b0, '0, 1'b1, 1'b0, "after_rst_pop");
        step(1'b0, '0, 1'b0, 1'b0, "after_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
